// File: rtl/serial_word_tx_if.sv
// Parallel-in / serial-out handshake bundle for serial_word_tx.
// The master modport is the word source; the slave modport is the transmitter.
interface serial_word_tx_if #(
  parameter int unsigned W = 6
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         out;
  logic         out_valid;
  logic         word_done;
  logic [7:0]   words_sent;

  modport master (
    output din, din_valid,
    input  din_ready, out, out_valid, word_done, words_sent
  );

  modport slave (
    input  din, din_valid,
    output din_ready, out, out_valid, word_done, words_sent
  );
endinterface

// File: rtl/serial_word_tx.sv
// Word-to-serial transmitter, MSB first, with a one-entry holding register
// so consecutive words leave back-to-back with no idle cycle.
module serial_word_tx #(
  parameter int unsigned W = 6
) (
  input  logic             clk,
  input  logic             reset,
  serial_word_tx_if.slave  bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q;
  logic [W-1:0]  sr_q;
  logic [W-1:0]  hold_q;
  logic [CW-1:0] cnt_q;
  logic          hold_full_q;
  logic [7:0]    words_sent_q;

  logic accept;
  logic shifting;
  logic last_bit;

  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (cnt_q == LAST);
  assign accept   = bus.din_valid && !hold_full_q;

  assign bus.din_ready  = !hold_full_q;
  assign bus.out_valid  = shifting;
  assign bus.out        = shifting ? sr_q[W-1] : 1'b0;
  assign bus.word_done  = last_bit;
  assign bus.words_sent = words_sent_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
      hold_full_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      if (last_bit) begin
        words_sent_q <= words_sent_q + 8'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sr_q    <= bus.din;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != LAST) begin
            sr_q  <= {sr_q[W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (accept) begin
              hold_q      <= bus.din;
              hold_full_q <= 1'b1;
            end
          end else if (hold_full_q) begin
            // din_ready is low here, so no new word can race the hold transfer
            sr_q        <= hold_q;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
          end else if (accept) begin
            sr_q  <= bus.din;
            cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: queue-based reference of the transmitted bit
// stream, directed scenarios plus a randomized source.
module tb_serial_word_tx;

  localparam int unsigned W = 6;

  logic clk;
  logic reset;

  serial_word_tx_if #(.W(W)) bus ();

  serial_word_tx #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference: words still owed on the wire, and how far into the head word we are.
  logic [W-1:0] mq[$];
  int           mpos;
  logic [7:0]   mcnt;

  // Log of what actually appeared on out while out_valid was high.
  logic [31:0]  log_bits;
  int           log_len;
  int           log_runs;
  logic         prev_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mpos = 0;
    mcnt = '0;
  endtask

  task automatic log_clear();
    log_bits   = '0;
    log_len    = 0;
    log_runs   = 0;
    prev_valid = 1'b0;
  endtask

  task automatic model_edge(input logic acc, input logic [W-1:0] d);
    if (mq.size() > 0) begin
      if (mpos == W - 1) begin
        void'(mq.pop_front());
        mpos = 0;
        mcnt = mcnt + 8'd1;
      end else begin
        mpos++;
      end
    end
    if (acc) mq.push_back(d);
  endtask

  // Check outputs for the current cycle, then present v/d for the next edge.
  task automatic step(input logic v, input logic [W-1:0] d, output logic acc);
    logic         mv;
    logic [W-1:0] head;
    logic         mo;
    @(negedge clk);
    mv   = (mq.size() > 0);
    head = mv ? mq[0] : '0;
    mo   = mv ? head[W-1-mpos] : 1'b0;
    check_eq("din_ready",  32'(bus.din_ready),  32'(mq.size() < 2));
    check_eq("out_valid",  32'(bus.out_valid),  32'(mv));
    check_eq("out",        32'(bus.out),        32'(mo));
    check_eq("word_done",  32'(bus.word_done),  32'(mv && (mpos == W - 1)));
    check_eq("words_sent", 32'(bus.words_sent), 32'(mcnt));
    if (bus.out_valid) begin
      log_bits = {log_bits[30:0], bus.out};
      log_len++;
      if (!prev_valid) log_runs++;
    end
    prev_valid    = bus.out_valid;
    bus.din_valid = v;
    bus.din       = d;
    acc           = v && (mq.size() < 2);
    @(posedge clk);
    model_edge(acc, d);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), a);
  endtask

  task automatic send_hold(input logic [W-1:0] w, output int tries);
    logic a;
    tries = 0;
    do begin
      step(1'b1, w, a);
      tries++;
    end while (!a && tries < 40);
    if (!a) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    log_clear();
  endtask

  initial begin
    logic a;
    int   tries;
    logic have;
    logic [W-1:0] pw;

    n_vec = 0;
    n_err = 0;
    model_clear();
    log_clear();
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    #1;
    check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("rst_out",        32'(bus.out),        32'd0);
    check_eq("rst_word_done",  32'(bus.word_done),  32'd0);
    check_eq("rst_din_ready",  32'(bus.din_ready),  32'd1);
    check_eq("rst_words_sent", 32'(bus.words_sent), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single word
    step(1'b1, 6'b110011, a);
    check_eq("single_acc", 32'(a), 32'd1);
    idle(9);
    check_eq("single_bits", log_bits, 32'b110011);
    check_eq("single_len",  32'(log_len), 32'd6);
    check_eq("single_cnt",  32'(bus.words_sent), 32'd1);
    check_eq("single_idle", 32'(bus.out_valid), 32'd0);

    // Back-to-back
    reset_dut();
    step(1'b1, 6'b110011, a);
    step(1'b1, 6'b101010, a);
    check_eq("b2b_acc2", 32'(a), 32'd1);
    idle(15);
    check_eq("b2b_bits", log_bits, 32'b110011101010);
    check_eq("b2b_len",  32'(log_len), 32'd12);
    check_eq("b2b_runs", 32'(log_runs), 32'd1);
    check_eq("b2b_cnt",  32'(bus.words_sent), 32'd2);

    // Streaming with din_valid held
    reset_dut();
    send_hold(6'b111000, tries);
    send_hold(6'b000111, tries);
    send_hold(6'b110011, tries);
    idle(20);
    check_eq("stream_bits", log_bits, 32'b111000000111110011);
    check_eq("stream_len",  32'(log_len), 32'd18);
    check_eq("stream_runs", 32'(log_runs), 32'd1);
    check_eq("stream_cnt",  32'(bus.words_sent), 32'd3);

    // Backpressure: third word must wait while hold is full
    reset_dut();
    step(1'b1, 6'b100001, a);
    step(1'b1, 6'b011110, a);
    send_hold(6'b101101, tries);
    check_eq("bp_stalled", 32'(tries > 1), 32'd1);
    idle(20);
    check_eq("bp_bits", log_bits, 32'b100001011110101101);
    check_eq("bp_runs", 32'(log_runs), 32'd1);
    check_eq("bp_cnt",  32'(bus.words_sent), 32'd3);

    // Reset mid-word with a word held
    reset_dut();
    step(1'b1, 6'b110011, a);
    step(1'b1, 6'b101010, a);
    tries = 0;
    while (mpos != 3 && tries < 20) begin
      step(1'b0, '0, a);
      tries++;
    end
    check_eq("mid_pos",  32'(mpos), 32'd3);
    check_eq("mid_hold", 32'(bus.din_ready), 32'd0);
    #2;
    reset         = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 6'b111111;
    #1;
    check_eq("mid_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("mid_out",        32'(bus.out),        32'd0);
    check_eq("mid_din_ready",  32'(bus.din_ready),  32'd1);
    check_eq("mid_words_sent", 32'(bus.words_sent), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    log_clear();
    idle(12);
    check_eq("mid_residual", 32'(log_len), 32'd0);

    // 256 words: counter must wrap back to 0
    reset_dut();
    for (int i = 0; i < 256; i++) send_hold(W'($urandom), tries);
    idle(16);
    check_eq("wrap_cnt",  32'(bus.words_sent), 32'd0);
    check_eq("wrap_len",  32'(log_len), 32'd1536);
    check_eq("wrap_runs", 32'(log_runs), 32'd1);

    // Randomized source holding din stable until accepted
    reset_dut();
    have = 1'b0;
    pw   = '0;
    for (int i = 0; i < 1200; i++) begin
      if (!have && ($urandom % 3) != 0) begin
        have = 1'b1;
        pw   = W'($urandom);
      end
      if (have) begin
        step(1'b1, pw, a);
        if (a) have = 1'b0;
      end else begin
        step(1'b0, W'($urandom), a);
      end
    end
    idle(20);
    check_eq("rand_drained", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter: W, default 6, word width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  W  parallel word to transmit.
REQ-005 Port: din_valid  input  1  din holds a word to transmit.
REQ-006 Port: din_ready  output  1  block can accept a word this cycle.
REQ-007 Port: out  output  1  serial data, MSB first.
REQ-008 Port: out_valid  output  1  out carries a valid bit this cycle.
REQ-009 Port: word_done  output  1  high during the last bit of each word.
REQ-010 Port: words_sent  output  8  count of completed words, modulo 256.

Function
REQ-011 A word SHALL be accepted at a rising edge where din_valid and din_ready are both high; no other event SHALL accept a word.
REQ-012 The block SHALL have two states, IDLE and SHIFT, plus a W-bit shift register sr, a bit counter cnt (0..W-1), and a one-entry holding register hold with flag hold_full.
REQ-013 din_ready SHALL equal !hold_full, combinationally.
REQ-014 In IDLE, an accepted word SHALL load directly into sr, clear cnt to 0, and move the state to SHIFT; hold SHALL stay empty.
REQ-015 In SHIFT with cnt < W-1, an accepted word SHALL go into hold and set hold_full.
REQ-016 In SHIFT with cnt < W-1, each edge SHALL shift sr left by one and increment cnt.
REQ-017 In SHIFT with cnt == W-1, the edge SHALL act as follows:
 - hold_full: sr <= hold, hold_full <= 0, cnt <= 0, stay in SHIFT.
 - else, if a word is accepted: sr <= din, cnt <= 0, stay in SHIFT.
 - otherwise: go to IDLE.
REQ-018 The cases in REQ-017 SHALL transmit back-to-back words with no idle cycle between them.
REQ-019 out_valid SHALL be high exactly when the state is SHIFT; out SHALL be sr[W-1] when out_valid is high and 0 otherwise.
REQ-020 Latency: a word accepted in IDLE at edge k SHALL drive its MSB on out in the cycle after edge k and its LSB W cycles after edge k.
REQ-021 Bit order example: W=6, din=6'b110011 SHALL produce out = 1,1,0,0,1,1 on consecutive cycles.
REQ-022 word_done SHALL equal out_valid && (cnt == W-1), combinationally.
REQ-023 words_sent SHALL increment by 1 at every edge where word_done is high, and SHALL wrap from 255 to 0.
REQ-024 While hold_full is high, din_valid SHALL be ignored; the source keeps din stable until acceptance.
REQ-025 The block SHALL never drop, duplicate, or reorder an accepted word.

Reset
REQ-026 While reset is high, the block SHALL immediately force: state IDLE, sr=0, cnt=0, hold=0, hold_full=0, words_sent=0.
REQ-027 While reset is high, the outputs SHALL read out=0, out_valid=0, word_done=0, din_ready=1, and no word SHALL be accepted.
REQ-028 Reset asserted mid-word SHALL abort that word and discard any held word.
REQ-029 After reset deasserts, the first rising edge SHALL process normally from IDLE.

Verification
REQ-030 Single word: after reset, present din=6'b110011 with din_valid for 1 cycle -> out_valid high for 6 cycles, out=1,1,0,0,1,1, word_done on the 6th bit only, then words_sent=1 and state IDLE.
REQ-031 Back-to-back: present 6'b110011, then 6'b101010 on the next cycle -> 12 contiguous out_valid cycles carrying 110011101010; din_ready=0 from acceptance of the 2nd word until its transfer into sr; words_sent=2.
REQ-032 Streaming: hold din_valid=1 for 3 words (6'b111000, 6'b000111, 6'b110011) -> 18 contiguous bits with no gap; words_sent=3.
REQ-033 Backpressure: assert din_valid with a new word while hold_full=1 -> word not accepted until din_ready rises, then transmitted intact immediately after the current and held words.
REQ-034 Reset mid-word: assert reset after 3 bits of 6'b110011 with a word held -> out_valid=0, out=0, din_ready=1, words_sent=0 in the same cycle; after release, no residual bits appear.
REQ-035 Counter wrap: transmit 256 words -> words_sent goes 255 -> 0 on the 256th word_done.
